// File: rtl/parity_sched.sv
// Round-robin scheduler sharing one bit-serial running-parity FSM between NREQ requesters.
// Optional build macro: PARITY_SCHED_ODD_EN (report the odd-parity bit instead of the even-parity bit).
module parity_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*WIDTH-1:0]    data_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic                     busy_o,
    output logic                     ser_bit_o,
    output logic                     done_o,
    output logic [$clog2(NREQ)-1:0]  done_id_o,
    output logic                     parity_o
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef PARITY_SCHED_ODD_EN
    localparam logic PAR_INV = 1'b1;
`else
    localparam logic PAR_INV = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_e;
    typedef enum logic {S0 = 1'b0, S1 = 1'b1} par_e;

    state_e            state_q, state_d;
    par_e              run_q, run_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     id_q, id_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     done_id_q, done_id_d;
    logic              parity_q, parity_d;
    logic              busy_q, done_q, ser_q;

    logic              pick_found_s;
    logic [IW-1:0]     pick_id_s;
    logic [IW:0]       cand_sum_s;
    logic [WIDTH-1:0]  sel_word_s;

    // Round-robin pick: first pending request at or above the pointer, wrapping.
    always_comb begin
        pick_found_s = 1'b0;
        pick_id_s    = {IW{1'b0}};
        cand_sum_s   = {(IW+1){1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            cand_sum_s = {1'b0, ptr_q} + (IW+1)'(i);
            cand_sum_s = (cand_sum_s >= (IW+1)'(NREQ)) ? cand_sum_s - (IW+1)'(NREQ) : cand_sum_s;
            if (!pick_found_s && req_i[cand_sum_s[IW-1:0]]) begin
                pick_found_s = 1'b1;
                pick_id_s    = cand_sum_s[IW-1:0];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Word of the granted requester, selected with constant slices.
    always_comb begin
        sel_word_s = {WIDTH{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (id_q == IW'(i)) begin
                sel_word_s = data_i[i*WIDTH +: WIDTH];
            end else begin
                sel_word_s = sel_word_s;
            end
        end
    end

    // Control FSM next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        gnt_d     = gnt_q;
        done_id_d = done_id_q;
        parity_d  = parity_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_id_s;
                    id_d    = pick_id_s;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                shreg_d = sel_word_s;
                run_d   = S0;
                cnt_d   = {CW{1'b0}};
                state_d = SHIFT;
            end
            SHIFT: begin
                run_d   = shreg_q[0] ? ((run_q == S0) ? S1 : S0) : run_q;
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d   = DONE;
                    gnt_d     = {NREQ{1'b0}};
                    done_id_d = id_q;
                    parity_d  = (run_d == S1) ^ PAR_INV;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                gnt_d   = {NREQ{1'b0}};
                ptr_d   = (id_q == IW'(NREQ - 1)) ? {IW{1'b0}} : id_q + IW'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; outputs are decoded from next state so they are flop-driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            run_q     <= S0;
            ptr_q     <= {IW{1'b0}};
            id_q      <= {IW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            shreg_q   <= {WIDTH{1'b0}};
            gnt_q     <= {NREQ{1'b0}};
            done_id_q <= {IW{1'b0}};
            parity_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ser_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            gnt_q     <= gnt_d;
            done_id_q <= done_id_d;
            parity_q  <= parity_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            ser_q     <= (state_d == SHIFT) ? shreg_d[0] : 1'b0;
        end
    end

    assign gnt_o     = gnt_q;
    assign busy_o    = busy_q;
    assign ser_bit_o = ser_q;
    assign done_o    = done_q;
    assign done_id_o = done_id_q;
    assign parity_o  = parity_q;

endmodule

// File: tb/tb_parity_sched.sv
// Self-checking bench for parity_sched: directed scenarios plus random traffic,
// all compared cycle by cycle against a service-age reference model.
module tb_parity_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
`ifdef PARITY_SCHED_ODD_EN
    localparam int ODD = 1;
`else
    localparam int ODD = 0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ*WIDTH-1:0]   data = '0;
    logic [NREQ-1:0]         gnt_o;
    logic                    busy_o, ser_bit_o, done_o, parity_o;
    logic [1:0]              done_id_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: transaction view, age = cycles since the grant edge.
    bit        m_busy;
    int        m_age, m_id, m_ptr, m_done_id;
    logic [WIDTH-1:0] m_word;
    logic      m_parity;

    parity_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .data_i(data),
        .gnt_o(gnt_o), .busy_o(busy_o), .ser_bit_o(ser_bit_o),
        .done_o(done_o), .done_id_o(done_id_o), .parity_o(parity_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_age = 0; m_id = 0; m_ptr = 0; m_done_id = 0;
        m_word = '0; m_parity = 1'b0;
    endtask

    task automatic model_edge();
        int j;
        if (!m_busy) begin
            for (int i = 0; i < NREQ; i++) begin
                j = (m_ptr + i) % NREQ;
                if (!m_busy && req[j]) begin
                    m_busy = 1; m_age = 1; m_id = j;
                end
            end
        end else begin
            m_age++;
            if (m_age == 2) m_word = data[m_id*WIDTH +: WIDTH];
            if (m_age == WIDTH + 2) begin
                m_done_id = m_id;
                m_parity  = logic'(($countones(m_word) + ODD) % 2);
            end
            if (m_age == WIDTH + 3) begin
                m_busy = 0;
                m_ptr  = (m_id + 1) % NREQ;
            end
        end
    endtask

    task automatic compare();
        logic [NREQ-1:0] eg;
        logic es;
        eg = (m_busy && m_age <= WIDTH + 1) ? NREQ'(1) << m_id : '0;
        es = (m_busy && m_age >= 2 && m_age <= WIDTH + 1) ? m_word[m_age-2] : 1'b0;
        check_eq("gnt",     gnt_o,     eg);
        check_eq("busy",    busy_o,    m_busy);
        check_eq("ser_bit", ser_bit_o, es);
        check_eq("done",    done_o,    (m_busy && m_age == WIDTH + 2));
        check_eq("done_id", done_id_o, m_done_id);
        check_eq("parity",  parity_o,  m_parity);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_gnt"},  gnt_o,  0);
        check_eq({tag, "_busy"}, busy_o, 0);
        check_eq({tag, "_done"}, done_o, 0);
        check_eq({tag, "_par"},  parity_o, 0);
        check_eq({tag, "_id"},   done_id_o, 0);
        check_eq({tag, "_ser"},  ser_bit_o, 0);
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        check_zero("rst");
        model_clear();
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int bound, output int cyc);
        bit got = 0;
        cyc = 0;
        while (!got && cyc < bound) begin
            step();
            cyc++;
            if (done_o) got = 1;
        end
        check_eq({tag, "_done_seen"}, got, 1);
    endtask

    initial begin
        int cyc, gcnt, last_done, nd;
        bit got;
        logic [WIDTH-1:0] ser_v;
        logic [NREQ-1:0] first_gnt;

        model_clear();
        // Reset with all requests asserted
        req  = 4'b1111;
        data = {$urandom, $urandom};
        apply_reset(3);
        req = 4'b0000;
        step();

        // Single request, even number of ones
        req = 4'b0010;
        data = $urandom;
        data[1*WIDTH +: WIDTH] = 8'hA5;
        gcnt = 0; got = 0; cyc = 0; ser_v = '0;
        for (int c = 1; c <= 20 && !got; c++) begin
            if (c == 2) req = 4'b0000;
            step();
            if (gnt_o == 4'b0010) gcnt++;
            if (c >= 2 && c <= 9) ser_v[c-2] = ser_bit_o;
            if (done_o) begin got = 1; cyc = c; end
        end
        check_eq("a5_seen",    got,  1);
        check_eq("a5_latency", cyc,  10);
        check_eq("a5_gnt_len", gcnt, 9);
        check_eq("a5_ser_seq", ser_v, 8'hA5);
        check_eq("a5_id",      done_id_o, 1);
        check_eq("a5_parity",  parity_o, ODD[0]);
        step();

        // Single request, odd number of ones
        req = 4'b0001;
        data[0 +: WIDTH] = 8'h07;
        step();
        req = 4'b0000;
        wait_done("w07", 20, cyc);
        check_eq("w07_id",     done_id_o, 0);
        check_eq("w07_parity", parity_o, 1 - ODD);
        repeat (2) step();

        // Round-robin with all requests held
        apply_reset(1);
        req = 4'b1111;
        nd = 0; last_done = 0;
        for (int c = 1; c <= 80 && nd < 5; c++) begin
            data = {$urandom, $urandom};
            step();
            if (done_o) begin
                check_eq("rr_order", done_id_o, nd % NREQ);
                if (nd > 0) check_eq("rr_spacing", c - last_done, WIDTH + 3);
                last_done = c;
                nd++;
            end
        end
        check_eq("rr_count", nd, 5);
        req = 4'b0000;
        repeat (12) step();

        // Reset during the fourth SHIFT cycle
        apply_reset(1);
        req = 4'b0001;
        step();
        req = 4'b0000;
        repeat (4) step();
        check_eq("mr_pre_busy", busy_o, 1);
        req = 4'b0100;
        apply_reset(2);
        first_gnt = '0;
        for (int c = 0; c < 5 && first_gnt == '0; c++) begin
            step();
            first_gnt = gnt_o;
        end
        check_eq("mr_gnt", first_gnt, 4'b0100);
        req = 4'b0000;
        wait_done("mr", 20, cyc);
        check_eq("mr_id", done_id_o, 2);
        step();

        // Request dropped during SHIFT
        req = 4'b1000;
        data = {$urandom, $urandom};
        repeat (3) step();
        req = 4'b0000;
        wait_done("drop", 20, cyc);
        check_eq("drop_id", done_id_o, 3);
        gcnt = 0;
        repeat (15) begin
            step();
            if (gnt_o != '0) gcnt++;
        end
        check_eq("drop_no_regrant", gcnt, 0);

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            req  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            data = {$urandom, $urandom};
            if ($urandom_range(0, 199) == 0) apply_reset(1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_sched.md
# parity_sched

Round-robin scheduler that shares one serial parity engine between `NREQ` requesters. It grants one requester at a time and captures its `WIDTH`-bit word. The word is fed LSB-first, one bit per clock, through a two-state running-parity FSM (states S0/S1). The block then reports the resulting parity bit with the requester's id. It sits between the word-level producers and the bit-serial parity datapath, and owns sequencing and arbitration for that datapath.

## Interface

- `NREQ`, 4, number of requesters (≥2)
- `WIDTH`, 8, bits per word (≥2)
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  NREQ  per-requester request level
- `data`  in  NREQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH]
- `gnt`  out  NREQ  one-hot grant, registered
- `busy`  out  1  high when the state is not IDLE
- `ser_bit`  out  1  bit fed to the parity FSM this cycle; 0 outside SHIFT
- `done`  out  1  one-cycle completion pulse
- `done_id`  out  $clog2(NREQ)  index of the requester just served
- `parity`  out  1  parity result, held until the next `done`

## Operation

- **Reset:** `rst_n` low clears all registers immediately.
  - Control state → IDLE; running parity → S0; RR pointer → 0; bit counter → 0; shift register → 0.
  - All outputs → 0.
- **FSM:** IDLE → LOAD → SHIFT → DONE → IDLE.
- **IDLE**
  - If any `req` bit is high, pick the first set bit searching from the RR pointer upward, wrapping at NREQ−1 → 0.
  - Register the one-hot `gnt` and the granted id, then go to LOAD.
  - If no request is pending, stay in IDLE.
- **LOAD**
  - Capture the granted requester's `data` slice into the shift register.
  - Running parity → S0; counter → 0; go to SHIFT.
- **SHIFT**
  - `ser_bit` = shift register LSB.
  - Running parity: S0→S1 if the bit is 1; S1→S0 if the bit is 1; otherwise unchanged.
  - Shift right and increment the counter.
  - After WIDTH SHIFT cycles, go to DONE.
- **DONE**
  - `done`=1; `done_id` = granted id; `parity` = final running parity (adjusted per Configuration).
  - `gnt` → 0; RR pointer → (granted id + 1) mod NREQ; go to IDLE.
- **Hold/drop rules**
  - `req` deassertion after grant is ignored; the service always completes.
  - `data` is sampled only in LOAD.
- **Boundaries**
  - Only one requester is ever granted at a time.
  - Other requests stay pending and are arbitrated in the next IDLE.
  - Reset mid-service abandons the word: no `done` is issued and the pointer returns to 0.

## Timing

- Request seen in IDLE at edge k:
  - `gnt` and `busy` are high from cycle k+1.
  - LOAD runs in k+1.
  - SHIFT runs in k+2 … k+WIDTH+1.
  - DONE and the `done` pulse occur in cycle k+WIDTH+2.
- `gnt` is high for WIDTH+1 cycles (LOAD + SHIFT).
- `busy` is high for WIDTH+2 cycles.
- Back-to-back service period is WIDTH+3 cycles, including one IDLE cycle.
- `parity` and `done_id` change only on entry to DONE; they are stable otherwise.

## Configuration

- `PARITY_SCHED_ODD_EN` defined:
  - `parity` = inverted running parity, i.e. the odd-parity bit: word plus `parity` contains an odd number of ones.
- Not defined:
  - `parity` = running parity (even-parity bit): 1 iff the word has an odd number of ones.
- The running FSM and `ser_bit` are identical in both builds.

## Test plan

- **Reset:** assert `rst_n`=0 with `req`=4'b1111 → `gnt`=0, `busy`=0, `done`=0, `parity`=0, `done_id`=0 throughout.
- **Single request, even ones:** `req`=4'b0010, word1=8'hA5.
  - `gnt`=4'b0010 for 9 cycles.
  - `done` at k+10, `done_id`=1, `parity`=0 (1 with `PARITY_SCHED_ODD_EN`).
  - `ser_bit` sequence 1,0,1,0,0,1,0,1.
- **Single request, odd ones:** word0=8'h07 → `parity`=1 (0 with the macro), `done_id`=0.
- **Round-robin:** `req`=4'b1111 held.
  - Grant order 0,1,2,3,0.
  - `done` pulses exactly 11 cycles apart.
- **Reset mid-SHIFT:** `rst_n` low in the 4th SHIFT cycle, then released with only `req`[2] high.
  - `gnt`/`busy` drop immediately; no `done`.
  - Next grant is 4'b0100; its `done` carries `done_id`=2.
- **Request drop:** `req`[3] falls during SHIFT → service completes with `done_id`=3 and correct parity; no further grant to 3.
